scale_coord_generator: RTL and testbench
========================================

Name: scale_coord_generator

Overview:
- Consumes one parameter set per pyramid scale from the scale-parameter stage: scaled width/height, base width/height and the X/Y scale factors.
- Emits a row-major stream of destination/source pixel coordinate pairs that drive the image-cache read side for nearest-neighbour downscaling.
- Source coordinates come from per-axis fixed-point accumulators, so the datapath needs no multiplier.

Parameters:
- FRAC_BITS, 12, fractional bits of the scale factors (ONE = 1<<FRAC_BITS).
- FACTOR_BITS, 32, width of scale factor inputs.
- W_BITS, 10, width of image width/x coordinates.
- H_BITS, 10, width of image height/y coordinates.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- sp_done  in  1  parameter set valid; level, held until taken
- sp_taken  out  1  parameter set consumed (one-cycle pulse)
- base_w  in  W_BITS  base image width
- base_h  in  H_BITS  base image height
- scale_w  in  W_BITS  scaled image width
- scale_h  in  H_BITS  scaled image height
- factor_x  in  FACTOR_BITS  X step, fixed point
- factor_y  in  FACTOR_BITS  Y step, fixed point
- co_valid  out  1  coordinate beat valid
- co_ready  in  1  downstream accepts beat
- dst_x  out  W_BITS  destination column
- dst_y  out  H_BITS  destination row
- src_x  out  W_BITS  source column
- src_y  out  H_BITS  source row
- co_last  out  1  final beat of frame
- frame_done  out  1  one-cycle pulse after last beat accepted
- busy  out  1  state != S_IDLE

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. All outputs, latched params, counters and accumulators are 0; state S_IDLE. Reset mid-frame abandons the frame with no frame_done.
- Registered state machine:
  - S_IDLE: sp_taken = sp_done (combinational). When sp_done=1, latch all params and go to S_LOAD.
  - S_LOAD: clear accX/accY, dst_x/dst_y = 0. If scale_w==0 or scale_h==0, go to S_FDONE. Otherwise go to S_RUN.
  - S_RUN: presents beats (below).
  - S_FDONE: frame_done=1 for exactly one cycle, then S_IDLE.
- Accumulators:
  - accX is FACTOR_BITS+W_BITS wide; accY is FACTOR_BITS+H_BITS wide. Both are unsigned, with no overflow possible at these widths.
  - Per beat: src = (acc + (ONE>>1)) >> FRAC_BITS, clamped to base-1 (and to 0 if base==0).
- Output register: co_valid, dst, src and co_last form one registered slice.
  - First beat is valid the cycle after S_LOAD.
  - While co_valid && !co_ready, all outputs hold stable.
  - On accept (co_valid && co_ready), the next beat is loaded in the same edge, so throughput is 1 beat/cycle.
- Advance rule on accept:
  - If dst_x < scale_w-1: dst_x++, accX += factor_x.
  - Otherwise: dst_x = 0, accX = 0, dst_y++, accY += factor_y.
- co_last = (dst_x==scale_w-1 && dst_y==scale_h-1). When a co_last beat is accepted, co_valid drops and the state moves to S_FDONE.
- Beats per frame = scale_w*scale_h exactly.
- sp_done asserted during S_RUN/S_FDONE is ignored (sp_taken=0) until S_IDLE is re-entered.

Optional Feature:
- Macro SCG_FRAC_OUT_EN.
- Defined:
  - src_x/src_y are floor(acc >> FRAC_BITS), clamped, with no rounding.
  - Extra output ports src_x_frac and src_y_frac (FRAC_BITS each) carry acc[FRAC_BITS-1:0]; they are registered with the beat and forced to 0 when clamped. These feed a future bilinear interpolator.
- Undefined: round-to-nearest as above; frac ports absent.

Decomposition:
- Package pkg_scaleCoordGen holds:
  - STATES_t enum {S_IDLE, S_LOAD, S_RUN, S_FDONE}
  - localparams ONE and HALF
  - a struct bundling the coordinate beat fields.
- One natural sub-module, scale_axis_stepper, instantiated twice (X, Y). It holds the accumulator, destination counter, wrap detect, round/clamp, and takes clear/step/wrap controls.

Test Plan:
- base 8x6, scale 4x3, factor 2.0 (8192) each axis, co_ready=1 -> 12 beats, one per cycle.
  - Row 0 src_x = 0,2,4,6; src_y per row = 0,2,4.
  - co_last on beat 12; frame_done one cycle later; sp_taken pulsed once.
- factor_x 1.5 (6144), scale_w 4, base_w 8 -> src_x = 0,2,3,5 (frac build: 0,1,3,4 with frac 0,2048,0,2048).
- Backpressure: toggle co_ready 1/0 every other cycle on the 4x3 case -> outputs stable while stalled, no beat lost or duplicated, 12 beats total.
- scale_w=0 with sp_done=1 -> sp_taken pulse, zero beats, frame_done exactly 2 cycles after the sp_taken cycle.
- base_w 5, scale_w 4, factor_x 1.75 (7168) -> src_x = 0,2,4,4 (5.25 clamped to 4).
- Assert resetn=0 after beat 5 -> next cycle co_valid=0, busy=0, no frame_done; a new sp_done restarts at dst 0,0.

Source files
------------

// File: rtl/scale_coord_generator_pkg.sv
// Shared types and constants for the pyramid-scale coordinate generator.
// SCG_FRAC_OUT_EN adds the fractional source-coordinate fields to the beat.
package pkg_scaleCoordGen;

   localparam int unsigned SCG_FRAC_BITS   = 12;
   localparam int unsigned SCG_FACTOR_BITS = 32;
   localparam int unsigned SCG_W_BITS      = 10;
   localparam int unsigned SCG_H_BITS      = 10;

   localparam int unsigned ONE  = 1 << SCG_FRAC_BITS;
   localparam int unsigned HALF = ONE >> 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FDONE
   } STATES_t;

   typedef struct packed {
      logic [SCG_W_BITS-1:0]    dst_x;
      logic [SCG_H_BITS-1:0]    dst_y;
      logic [SCG_W_BITS-1:0]    src_x;
      logic [SCG_H_BITS-1:0]    src_y;
`ifdef SCG_FRAC_OUT_EN
      logic [SCG_FRAC_BITS-1:0] src_x_frac;
      logic [SCG_FRAC_BITS-1:0] src_y_frac;
`endif
      logic                     last;
   } coord_beat_t;

endpackage

// File: rtl/scale_coord_generator_axis_stepper.sv
// One axis of the coordinate walk: destination counter, fixed-point source accumulator and
// round/clamp. Outputs describe the beat that will be presented after this edge.
module scale_axis_stepper
   import pkg_scaleCoordGen::*;
#(
   parameter int unsigned FRAC_BITS   = SCG_FRAC_BITS,
   parameter int unsigned FACTOR_BITS = SCG_FACTOR_BITS,
   parameter int unsigned C_BITS      = SCG_W_BITS
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   clear,
   input  logic                   step,
   input  logic                   wrap,
   input  logic [C_BITS-1:0]      size,
   input  logic [C_BITS-1:0]      base,
   input  logic [FACTOR_BITS-1:0] factor,
   output logic                   at_last,
   output logic [C_BITS-1:0]      nxt_dst,
   output logic [C_BITS-1:0]      nxt_src,
`ifdef SCG_FRAC_OUT_EN
   output logic [FRAC_BITS-1:0]   nxt_frac,
`endif
   output logic                   nxt_last
);

   localparam int unsigned ACC_BITS = FACTOR_BITS + C_BITS;
   localparam int unsigned INT_BITS = ACC_BITS - FRAC_BITS;

   logic [ACC_BITS-1:0] acc_q, acc_d;
   logic [C_BITS-1:0]   dst_q, dst_d;
   logic [C_BITS-1:0]   last_idx;
   logic [C_BITS-1:0]   base_max;
   logic [INT_BITS-1:0] whole;
   logic                clamp;

   assign last_idx = size - C_BITS'(1);
   assign base_max = base - C_BITS'(1);

   always_comb begin
      acc_d = acc_q;
      dst_d = dst_q;
      if (clear || wrap) begin
         acc_d = '0;
         dst_d = '0;
      end else if (step) begin
         acc_d = acc_q + ACC_BITS'(factor);
         dst_d = dst_q + C_BITS'(1);
      end
   end

`ifdef SCG_FRAC_OUT_EN
   assign whole = INT_BITS'(acc_d >> FRAC_BITS);
`else
   localparam logic [ACC_BITS-1:0] RND = ACC_BITS'(64'd1 << (FRAC_BITS - 1));
   assign whole = INT_BITS'((acc_d + RND) >> FRAC_BITS);
`endif

   // An empty base image maps every destination onto source 0.
   assign clamp = (base == '0) || (whole > INT_BITS'(base_max));

   always_comb begin
      nxt_src = whole[C_BITS-1:0];
      if (base == '0) begin
         nxt_src = '0;
      end else if (clamp) begin
         nxt_src = base_max;
      end
   end

`ifdef SCG_FRAC_OUT_EN
   assign nxt_frac = clamp ? '0 : acc_d[FRAC_BITS-1:0];
`endif

   assign nxt_dst  = dst_d;
   assign nxt_last = (dst_d == last_idx);
   assign at_last  = (dst_q == last_idx);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_q <= '0;
         dst_q <= '0;
      end else begin
         acc_q <= acc_d;
         dst_q <= dst_d;
      end
   end

endmodule

// File: rtl/scale_coord_generator.sv
// Row-major destination/source coordinate stream for nearest-neighbour pyramid downscaling.
// Define SCG_FRAC_OUT_EN for truncated source coordinates plus src_x_frac/src_y_frac outputs.
module scale_coord_generator
   import pkg_scaleCoordGen::*;
#(
   parameter int unsigned FRAC_BITS   = SCG_FRAC_BITS,
   parameter int unsigned FACTOR_BITS = SCG_FACTOR_BITS,
   parameter int unsigned W_BITS      = SCG_W_BITS,
   parameter int unsigned H_BITS      = SCG_H_BITS
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   sp_done,
   output logic                   sp_taken,
   input  logic [W_BITS-1:0]      base_w,
   input  logic [H_BITS-1:0]      base_h,
   input  logic [W_BITS-1:0]      scale_w,
   input  logic [H_BITS-1:0]      scale_h,
   input  logic [FACTOR_BITS-1:0] factor_x,
   input  logic [FACTOR_BITS-1:0] factor_y,
   output logic                   co_valid,
   input  logic                   co_ready,
   output logic [W_BITS-1:0]      dst_x,
   output logic [H_BITS-1:0]      dst_y,
   output logic [W_BITS-1:0]      src_x,
   output logic [H_BITS-1:0]      src_y,
`ifdef SCG_FRAC_OUT_EN
   output logic [FRAC_BITS-1:0]   src_x_frac,
   output logic [FRAC_BITS-1:0]   src_y_frac,
`endif
   output logic                   co_last,
   output logic                   frame_done,
   output logic                   busy
);

   STATES_t state;

   logic [W_BITS-1:0]      base_w_q, scale_w_q;
   logic [H_BITS-1:0]      base_h_q, scale_h_q;
   logic [FACTOR_BITS-1:0] factor_x_q, factor_y_q;

   coord_beat_t beat_q, beat_nxt;

   logic accept, clear;
   logic x_at_last, y_at_last;
   logic x_nxt_last, y_nxt_last;
   logic [W_BITS-1:0] x_nxt_dst, x_nxt_src;
   logic [H_BITS-1:0] y_nxt_dst, y_nxt_src;
`ifdef SCG_FRAC_OUT_EN
   logic [FRAC_BITS-1:0] x_nxt_frac, y_nxt_frac;
`endif

   assign accept = (state == S_RUN) && co_valid && co_ready;
   assign clear  = (state == S_LOAD);

   scale_axis_stepper #(
      .FRAC_BITS   (FRAC_BITS),
      .FACTOR_BITS (FACTOR_BITS),
      .C_BITS      (W_BITS)
   ) u_step_x (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (clear),
      .step     (accept && !x_at_last),
      .wrap     (accept && x_at_last),
      .size     (scale_w_q),
      .base     (base_w_q),
      .factor   (factor_x_q),
      .at_last  (x_at_last),
      .nxt_dst  (x_nxt_dst),
      .nxt_src  (x_nxt_src),
`ifdef SCG_FRAC_OUT_EN
      .nxt_frac (x_nxt_frac),
`endif
      .nxt_last (x_nxt_last)
   );

   // Y only advances on a row wrap and holds on the final row of the frame.
   scale_axis_stepper #(
      .FRAC_BITS   (FRAC_BITS),
      .FACTOR_BITS (FACTOR_BITS),
      .C_BITS      (H_BITS)
   ) u_step_y (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (clear),
      .step     (accept && x_at_last && !y_at_last),
      .wrap     (1'b0),
      .size     (scale_h_q),
      .base     (base_h_q),
      .factor   (factor_y_q),
      .at_last  (y_at_last),
      .nxt_dst  (y_nxt_dst),
      .nxt_src  (y_nxt_src),
`ifdef SCG_FRAC_OUT_EN
      .nxt_frac (y_nxt_frac),
`endif
      .nxt_last (y_nxt_last)
   );

   always_comb begin
      beat_nxt       = '0;
      beat_nxt.dst_x = x_nxt_dst;
      beat_nxt.dst_y = y_nxt_dst;
      beat_nxt.src_x = x_nxt_src;
      beat_nxt.src_y = y_nxt_src;
`ifdef SCG_FRAC_OUT_EN
      beat_nxt.src_x_frac = x_nxt_frac;
      beat_nxt.src_y_frac = y_nxt_frac;
`endif
      beat_nxt.last  = x_nxt_last && y_nxt_last;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         base_w_q   <= '0;
         base_h_q   <= '0;
         scale_w_q  <= '0;
         scale_h_q  <= '0;
         factor_x_q <= '0;
         factor_y_q <= '0;
         beat_q     <= '0;
         co_valid   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (sp_done) begin
                  base_w_q   <= base_w;
                  base_h_q   <= base_h;
                  scale_w_q  <= scale_w;
                  scale_h_q  <= scale_h;
                  factor_x_q <= factor_x;
                  factor_y_q <= factor_y;
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (scale_w_q == '0 || scale_h_q == '0) begin
                  state      <= S_FDONE;
                  frame_done <= 1'b1;
               end else begin
                  beat_q   <= beat_nxt;
                  co_valid <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (beat_q.last) begin
                     co_valid   <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= S_FDONE;
                  end else begin
                     beat_q <= beat_nxt;
                  end
               end
            end
            S_FDONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign sp_taken = (state == S_IDLE) && sp_done;
   assign busy     = (state != S_IDLE);
   assign dst_x    = beat_q.dst_x;
   assign dst_y    = beat_q.dst_y;
   assign src_x    = beat_q.src_x;
   assign src_y    = beat_q.src_y;
`ifdef SCG_FRAC_OUT_EN
   assign src_x_frac = beat_q.src_x_frac;
   assign src_y_frac = beat_q.src_y_frac;
`endif
   assign co_last  = beat_q.last;

endmodule

// File: tb/tb_scale_coord_generator.sv
// Scoreboard bench for scale_coord_generator; expected beats come from a direct x*factor model.
// Build with SCG_FRAC_OUT_EN to exercise the truncating/fractional variant.
`timescale 1ns/1ps
module tb_scale_coord_generator;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sp_done = 1'b0;
   logic        sp_taken;
   logic [9:0]  base_w = '0, base_h = '0, scale_w = '0, scale_h = '0;
   logic [31:0] factor_x = '0, factor_y = '0;
   logic        co_valid;
   logic        co_ready = 1'b1;
   logic [9:0]  dst_x, dst_y, src_x, src_y;
   logic        co_last, frame_done, busy;
`ifdef SCG_FRAC_OUT_EN
   logic [11:0] src_x_frac, src_y_frac;
`endif

   scale_coord_generator dut (
      .clk        (clk),
      .resetn     (resetn),
      .sp_done    (sp_done),
      .sp_taken   (sp_taken),
      .base_w     (base_w),
      .base_h     (base_h),
      .scale_w    (scale_w),
      .scale_h    (scale_h),
      .factor_x   (factor_x),
      .factor_y   (factor_y),
      .co_valid   (co_valid),
      .co_ready   (co_ready),
      .dst_x      (dst_x),
      .dst_y      (dst_y),
      .src_x      (src_x),
      .src_y      (src_y),
`ifdef SCG_FRAC_OUT_EN
      .src_x_frac (src_x_frac),
      .src_y_frac (src_y_frac),
`endif
      .co_last    (co_last),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int dx, dy, sx, sy, lst, fxr, fyr;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc_n = 0, taken_cnt = 0, beat_cnt = 0, fd_cnt = 0;
   int   taken_cyc = 0, last_cyc = 0;
   bit   zero_frame = 0;
   bit   bp_mode = 0;
   bit   stall_prev = 0;
   logic [63:0] snap_prev;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: src = round(acc/ONE) (or floor in the frac build), clamped into the base image.
   task automatic model(input longint unsigned acc, input int base, output int src,
                        output int frac);
      longint unsigned v;
`ifdef SCG_FRAC_OUT_EN
      v = acc >> 12;
`else
      v = (acc + 2048) >> 12;
`endif
      if (base == 0) begin
         src = 0; frac = 0;
      end else if (v > longint'(base - 1)) begin
         src = base - 1; frac = 0;
      end else begin
         src = int'(v); frac = int'(acc & 64'hfff);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (bp_mode) co_ready = ~co_ready;
      else co_ready = 1'b1;
   end

   always @(negedge clk) begin
      exp_t e;
      logic [63:0] snap;
      cyc_n++;
      if (sp_taken) begin
         taken_cnt++;
         taken_cyc = cyc_n;
      end
      if (resetn && co_valid && co_ready) begin
         if (sbq.size() == 0) begin
            check_eq("unexpected_beat", 1, 0);
         end else begin
            e = sbq.pop_front();
            check_eq("dst_x", dst_x, e.dx);
            check_eq("dst_y", dst_y, e.dy);
            check_eq("src_x", src_x, e.sx);
            check_eq("src_y", src_y, e.sy);
            check_eq("co_last", co_last, e.lst);
`ifdef SCG_FRAC_OUT_EN
            check_eq("src_x_frac", src_x_frac, e.fxr);
            check_eq("src_y_frac", src_y_frac, e.fyr);
`endif
            beat_cnt++;
            if (co_last) last_cyc = cyc_n;
         end
      end
      if (frame_done) begin
         fd_cnt++;
         check_eq("frame_done_timing", cyc_n, zero_frame ? taken_cyc + 2 : last_cyc + 1);
      end
      snap = {22'd0, co_valid, co_last, dst_x, dst_y, src_x, src_y};
      if (stall_prev) check_eq("hold_stable", snap, snap_prev);
      stall_prev = resetn && co_valid && !co_ready;
      snap_prev  = snap;
   end

   task automatic start_frame(input int bw, input int bh, input int sw, input int sh,
                              input int fx, input int fy);
      exp_t e;
      for (int y = 0; y < sh; y++) begin
         for (int x = 0; x < sw; x++) begin
            e.dx  = x;
            e.dy  = y;
            e.lst = (x == sw - 1 && y == sh - 1) ? 1 : 0;
            model(longint'(x) * longint'(fx), bw, e.sx, e.fxr);
            model(longint'(y) * longint'(fy), bh, e.sy, e.fyr);
            sbq.push_back(e);
         end
      end
      taken_cnt  = 0;
      beat_cnt   = 0;
      fd_cnt     = 0;
      zero_frame = (sw == 0 || sh == 0);
      @(posedge clk); #1;
      base_w = 10'(bw); base_h = 10'(bh); scale_w = 10'(sw); scale_h = 10'(sh);
      factor_x = 32'(fx); factor_y = 32'(fy);
      sp_done = 1'b1;
      @(negedge clk);
      check_eq("sp_taken_idle", sp_taken, 1);
      @(posedge clk); #1;
      if (!zero_frame) begin
         // Held request must be ignored while the frame is in flight.
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("sp_taken_busy", sp_taken, 0);
            check_eq("busy", busy, 1);
         end
         @(posedge clk); #1;
      end
      sp_done = 1'b0;
   endtask

   task automatic finish_frame(input int nbeats);
      for (int i = 0; i < 300 && fd_cnt == 0; i++) begin
         @(negedge clk); #1;
      end
      check_eq("frame_done_count", fd_cnt, 1);
      @(negedge clk);
      check_eq("frame_done_pulse", frame_done, 0);
      check_eq("idle_after_frame", busy, 0);
      check_eq("beat_count", beat_cnt, nbeats);
      check_eq("sbq_empty", sbq.size(), 0);
      check_eq("taken_count", taken_cnt, 1);
      sbq.delete();
   endtask

   task automatic run_frame(input int bw, input int bh, input int sw, input int sh,
                            input int fx, input int fy);
      start_frame(bw, bh, sw, sh, fx, fy);
      finish_frame(sw * sh);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_co_valid", co_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_dst_x", dst_x, 0);
      check_eq("rst_src_y", src_y, 0);
      @(posedge clk); #1;
      resetn = 1'b1;

      run_frame(8, 6, 4, 3, 8192, 8192);
      run_frame(8, 6, 4, 2, 6144, 8192);
      bp_mode = 1;
      run_frame(8, 6, 4, 3, 8192, 8192);
      bp_mode = 0;
      run_frame(8, 6, 0, 3, 8192, 8192);
      run_frame(5, 0, 4, 2, 7168, 4096);
      run_frame(3, 3, 1, 1, 4096, 4096);

      // Mid-frame reset: abandon after five beats, then restart cleanly.
      start_frame(8, 6, 4, 3, 8192, 8192);
      for (int i = 0; i < 100 && beat_cnt < 5; i++) begin
         @(negedge clk); #1;
      end
      check_eq("beats_before_reset", beat_cnt, 5);
      resetn = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_co_valid", co_valid, 0);
      check_eq("rst_mid_busy", busy, 0);
      sbq.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("rst_mid_no_frame_done", fd_cnt, 0);
      run_frame(8, 6, 4, 3, 8192, 8192);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=%0d exp=%0d", cyc_n, 0);
      $fatal(1, "watchdog");
   end

endmodule
